ahb_arbiter: RTL and testbench

- Round-robin AHB bus arbiter that shares the AHB slave port between NUM_MASTERS requesting masters.
- Drives one-hot HGRANT, and the registered HMASTER / HMASTLOCK used by the address and data muxes.
- Never breaks a fixed-length burst or a locked sequence.
- Parks the bus on DEFAULT_MASTER when nobody requests.

---
 rtl/ahb_arbiter.sv | 152 +++++++++++++++
 tb/tb_ahb_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter: one-hot HGRANT, registered HMASTER/HMASTLOCK.
// Define AHB_ARB_BURST_LIMIT_EN to cap undefined-length INCR bursts at MAX_BEATS.
module ahb_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int MW             = 2,
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_BEATS      = 16
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MW-1:0]          HMASTER,
    output logic                   HMASTLOCK
);

    localparam int LIM = (MAX_BEATS > 16) ? MAX_BEATS : 16;
    localparam int CW  = $clog2(LIM + 1);
    localparam logic [MW-1:0] DEF = MW'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] ONE = NUM_MASTERS'(1);

    typedef enum logic [1:0] {PARK, BURST, LOCKED} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   beat_cnt, cnt_n;
    logic            fixed_act, fixed_n;
    logic            incr_act, incr_n;
    logic [MW-1:0]   last_grant, gidx, sel;
    logic            found, ap, freeze, others;
    int              idx;

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_MASTERS; i++)
            if (HGRANT[i]) gidx = MW'(i);
    end

    // Scan starts just past the last winner and wraps back to index 0.
    always_comb begin
        found = 1'b0;
        sel   = DEF;
        idx   = 0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx = (int'(last_grant) + i) % NUM_MASTERS;
            if (!found && HBUSREQ[MW'(idx)]) begin
                found = 1'b1;
                sel   = MW'(idx);
            end
        end
    end

    assign freeze = HLOCK[gidx];
    assign others = |(HBUSREQ & ~HGRANT);

    // beat_cnt holds the beats still to follow the current address phase.
    always_comb begin
        ap      = 1'b0;
        fixed_n = fixed_act;
        incr_n  = incr_act;
        cnt_n   = beat_cnt;
        unique case (HTRANS)
            2'b00: begin
                ap      = 1'b1;
                fixed_n = 1'b0;
                incr_n  = 1'b0;
                cnt_n   = '0;
            end
            2'b10: begin
                if (HBURST == 3'b000) begin
                    ap      = 1'b1;
                    fixed_n = 1'b0;
                    incr_n  = 1'b0;
                    cnt_n   = '0;
                end else if (HBURST == 3'b001) begin
                    fixed_n = 1'b0;
                    incr_n  = 1'b1;
`ifdef AHB_ARB_BURST_LIMIT_EN
                    cnt_n   = CW'(2);
`else
                    cnt_n   = '0;
`endif
                end else begin
                    fixed_n = 1'b1;
                    incr_n  = 1'b0;
                    unique case (HBURST[2:1])
                        2'b01:   cnt_n = CW'(2);
                        2'b10:   cnt_n = CW'(6);
                        default: cnt_n = CW'(14);
                    endcase
                end
            end
            2'b11: begin
                if (fixed_act) begin
                    ap = (beat_cnt == CW'(1));
                    if (beat_cnt == '0) fixed_n = 1'b0;
                    else                cnt_n   = beat_cnt - CW'(1);
                end else if (incr_act) begin
`ifdef AHB_ARB_BURST_LIMIT_EN
                    if (beat_cnt >= CW'(MAX_BEATS) && others) begin
                        ap      = 1'b1;
                        incr_n  = 1'b0;
                        fixed_n = 1'b1;
                        cnt_n   = '0;
                    end else if (beat_cnt < CW'(MAX_BEATS)) begin
                        cnt_n   = beat_cnt + CW'(1);
                    end
`endif
                end else begin
                    ap = (state == PARK);
                end
            end
            default: ap = !(fixed_act || incr_act);
        endcase
        if (freeze)                   state_n = LOCKED;
        else if (fixed_n || incr_n)   state_n = BURST;
        else                          state_n = PARK;
        if (freeze) ap = 1'b0;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            HGRANT     <= ONE << DEF;
            HMASTER    <= DEF;
            HMASTLOCK  <= 1'b0;
            beat_cnt   <= '0;
            last_grant <= DEF;
            state      <= PARK;
            fixed_act  <= 1'b0;
            incr_act   <= 1'b0;
        end else if (HREADY) begin
            state     <= state_n;
            fixed_act <= fixed_n;
            incr_act  <= incr_n;
            beat_cnt  <= cnt_n;
            HMASTER   <= gidx;
            HMASTLOCK <= HLOCK[gidx];
            if (ap) begin
                if (found) begin
                    HGRANT     <= ONE << sel;
                    last_grant <= sel;
                end else begin
                    HGRANT     <= ONE << DEF;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: park, rotation, bursts, lock, stall, reset.
// Build with AHB_ARB_BURST_LIMIT_EN to exercise the INCR beat limit.
module tb_ahb_arbiter;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] BUSY = 2'b01;
    localparam logic [1:0] NS   = 2'b10;
    localparam logic [1:0] SEQ  = 2'b11;
    localparam logic [2:0] SGL  = 3'b000;
    localparam logic [2:0] INC  = 3'b001;
    localparam logic [2:0] INC4 = 3'b011;
    localparam logic [2:0] INC8 = 3'b101;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] busreq, hlock;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       ready;
    logic [3:0] grant;
    logic [1:0] master;
    logic       mlock;

    int checks   = 0;
    int failures = 0;

    logic [3:0] rr_g [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] rr_m [4] = '{2'd0, 2'd1, 2'd2, 2'd3};

    always #5 clk = ~clk;

    ahb_arbiter #(
        .NUM_MASTERS(4), .MW(2), .DEFAULT_MASTER(0), .MAX_BEATS(4)
    ) dut (
        .HCLK(clk), .HRESET(rst), .HBUSREQ(busreq), .HLOCK(hlock),
        .HTRANS(trans), .HBURST(burst), .HREADY(ready),
        .HGRANT(grant), .HMASTER(master), .HMASTLOCK(mlock)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [1:0] t, input logic [2:0] b);
        trans = t;
        burst = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; busreq = '0; hlock = '0;
        trans = IDLE; burst = SGL; ready = 1'b1;
        #12;
        check("rst_grant", 32'(grant), 32'h1);
        check("rst_master", 32'(master), 32'h0);
        check("rst_lock", 32'(mlock), 32'h0);
        @(negedge clk) rst = 1'b0;

        repeat (3) step(IDLE, SGL);
        check("park_grant", 32'(grant), 32'h1);
        check("park_master", 32'(master), 32'h0);
        check("park_lock", 32'(mlock), 32'h0);

        busreq = 4'hF;
        for (int i = 0; i < 4; i++) begin
            step(NS, SGL);
            check("rr_grant", 32'(grant), 32'(rr_g[i]));
            check("rr_master", 32'(master), 32'(rr_m[i]));
        end

        busreq = 4'b0010;
        step(IDLE, SGL);
        check("b4_pre_grant", 32'(grant), 32'h2);
        step(IDLE, SGL);
        check("b4_pre_master", 32'(master), 32'h1);
        busreq = 4'b0110;
        step(NS, INC4);
        check("b4_ns", 32'(grant), 32'h2);
        step(SEQ, INC4);
        check("b4_seq1", 32'(grant), 32'h2);
        step(SEQ, INC4);
        check("b4_switch", 32'(grant), 32'h4);
        step(SEQ, INC4);
        check("b4_last", 32'(grant), 32'h4);
        check("b4_master", 32'(master), 32'h2);

        busreq = 4'b1000;
        step(IDLE, SGL);
        check("lk_pre", 32'(grant), 32'h8);
        hlock = 4'b1000;
        busreq = 4'hF;
        for (int i = 0; i < 5; i++) begin
            step(NS, SGL);
            check("lk_grant", 32'(grant), 32'h8);
        end
        check("lk_mlock", 32'(mlock), 32'h1);
        check("lk_master", 32'(master), 32'h3);
        hlock = '0;
        step(NS, SGL);
        check("lk_release", 32'(grant), 32'h1);
        check("lk_mlock_off", 32'(mlock), 32'h0);

        busreq = 4'b0001;
        step(IDLE, SGL);
        check("st_pre", 32'(grant), 32'h1);
        busreq = 4'b0011;
        step(NS, INC8);
        check("st_ns", 32'(grant), 32'h1);
        repeat (3) step(SEQ, INC8);
        check("st_seq3", 32'(grant), 32'h1);
        ready = 1'b0;
        repeat (2) begin
            step(SEQ, INC8);
            check("st_hold_grant", 32'(grant), 32'h1);
            check("st_hold_master", 32'(master), 32'h0);
        end
        ready = 1'b1;
        step(SEQ, INC8);
        check("st_seq4", 32'(grant), 32'h1);
        step(SEQ, INC8);
        check("st_seq5", 32'(grant), 32'h1);
        step(SEQ, INC8);
        check("st_switch", 32'(grant), 32'h2);
        step(SEQ, INC8);
        step(NS, INC4);
        check("mr_master", 32'(master), 32'h1);
        check("mr_grant", 32'(grant), 32'h2);
        #2 rst = 1'b1;
        #1;
        check("mr_rst_grant", 32'(grant), 32'h1);
        check("mr_rst_master", 32'(master), 32'h0);
        check("mr_rst_lock", 32'(mlock), 32'h0);
        @(negedge clk) rst = 1'b0;
        busreq = 4'b0100;
        #4;
        step(SEQ, INC4);
        check("mr_abort", 32'(grant), 32'h4);

        busreq = 4'b0001;
        step(IDLE, SGL);
        step(IDLE, SGL);
        check("in_pre", 32'(grant), 32'h1);
        busreq = 4'b0101;
        step(NS, INC);
        check("in_ns", 32'(grant), 32'h1);
        step(SEQ, INC);
        check("in_seq1", 32'(grant), 32'h1);
        step(SEQ, INC);
        check("in_seq2", 32'(grant), 32'h1);
        step(SEQ, INC);
`ifdef AHB_ARB_BURST_LIMIT_EN
        check("lim_switch", 32'(grant), 32'h4);
        step(SEQ, INC);
        check("lim_after", 32'(grant), 32'h4);
`else
        check("in_seq3", 32'(grant), 32'h1);
        step(BUSY, INC);
        check("in_busy", 32'(grant), 32'h1);
        repeat (4) step(SEQ, INC);
        check("in_hold", 32'(grant), 32'h1);
        step(IDLE, SGL);
        check("in_end", 32'(grant), 32'h4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
